// File: rtl/dv_test_sequencer.sv
// dv_test_sequencer: sequenced DUT reset, per-channel
// start levels, status aggregation and a cycle watchdog.
module dv_test_sequencer #(
  parameter int unsigned N            = 1,
  parameter int unsigned RESET_CYCLES = 20,
  parameter int unsigned TIMEOUT      = 10000,
  parameter int unsigned DRAIN        = 16,
  parameter int unsigned CW           = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  dut_active,
  input  logic [N-1:0]  stim_done,
  input  logic [N-1:0]  test_done,
  input  logic [N-1:0]  error,
  output logic          dut_nreset,
  output logic [N-1:0]  start,
  output logic          finish,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int unsigned HW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned DW = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_RUN,
    S_DRAIN,
    S_END
  } state_t;

  state_t        state, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [DW-1:0] drain_cnt, drain_d;
  logic [CW-1:0] cycles_d, cycles_inc;
  logic [N-1:0]  start_d;
  logic          dut_nreset_d;
  logic          finish_d, pass_d, fail_d, timeout_d;
  logic          error_sticky, sticky_d;
  logic          err_now, hold_last, drain_last;
  logic          tmo_hit, all_done;

  // Terminal-condition decodes shared by the next-state logic
  always_comb begin
    hold_last  = (hold_cnt == HW'(RESET_CYCLES - 1));
    drain_last = (drain_cnt == DW'(DRAIN - 1));
    tmo_hit    = (TIMEOUT != 0) &&
                 (cycles == CW'(TIMEOUT - 1));
    all_done   = (&stim_done) && (&test_done);
    cycles_inc = (&cycles) ? cycles : cycles + CW'(1);
    err_now    = error_sticky |
                 ((|error) & dut_nreset & (state != S_END));
  end

  // Next-state and next-output logic for the test phases
  always_comb begin
    state_d      = state;
    hold_d       = hold_cnt;
    drain_d      = drain_cnt;
    cycles_d     = cycles;
    start_d      = start;
    dut_nreset_d = dut_nreset;
    finish_d     = finish;
    pass_d       = pass;
    fail_d       = fail;
    timeout_d    = timeout;
    sticky_d     = err_now;
    unique case (state)
      S_HOLD: begin
        hold_d = hold_cnt + HW'(1);
        if (hold_last) begin
          dut_nreset_d = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        start_d = start | dut_active;
        if (tmo_hit) begin
          state_d   = S_END;
          timeout_d = 1'b1;
          finish_d  = 1'b1;
          fail_d    = 1'b1;
        end else begin
          cycles_d = cycles_inc;
          if (&start) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (all_done) begin
          state_d  = S_DRAIN;
          drain_d  = '0;
          cycles_d = cycles_inc;
        end else if (tmo_hit) begin
          state_d   = S_END;
          timeout_d = 1'b1;
          finish_d  = 1'b1;
          fail_d    = 1'b1;
        end else begin
          cycles_d = cycles_inc;
        end
      end
      S_DRAIN: begin
        drain_d = drain_cnt + DW'(1);
        if (drain_last) begin
          state_d  = S_END;
          finish_d = 1'b1;
          pass_d   = ~err_now & ~timeout;
          fail_d   = err_now | timeout;
        end
      end
      S_END: begin
        state_d = S_END;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  // State and output registers, cleared by the async reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= S_HOLD;
      hold_cnt     <= '0;
      drain_cnt    <= '0;
      cycles       <= '0;
      start        <= '0;
      dut_nreset   <= 1'b0;
      finish       <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      error_sticky <= 1'b0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_d;
      drain_cnt    <= drain_d;
      cycles       <= cycles_d;
      start        <= start_d;
      dut_nreset   <= dut_nreset_d;
      finish       <= finish_d;
      pass         <= pass_d;
      fail         <= fail_d;
      timeout      <= timeout_d;
      error_sticky <= sticky_d;
    end
  end

endmodule

// File: tb/tb_dv_test_sequencer.sv
// tb_dv_test_sequencer: directed and random scenarios
// checked against an event-time model of the sequencer.
module tb_dv_test_sequencer;

  localparam int N   = 4;
  localparam int RC  = 20;
  localparam int TMO = 200;
  localparam int DR  = 16;
  localparam int CW  = 16;
  localparam int NEVER = 1000000;

  logic          clk = 1'b0;
  logic          nreset;
  logic [N-1:0]  dut_active, stim_done, test_done, error;
  logic          dut_nreset, finish, pass, fail, timeout;
  logic [N-1:0]  start;
  logic [CW-1:0] cycles;

  int checks   = 0;
  int failures = 0;

  int a_t[N], drop_t[N], sd_t[N], td_t[N];
  int err_k, abort_k;
  logic [N-1:0] err_val;

  always #5 clk = ~clk;

  dv_test_sequencer #(
    .N(N), .RESET_CYCLES(RC), .TIMEOUT(TMO),
    .DRAIN(DR), .CW(CW)
  ) dut (
    .clk(clk), .nreset(nreset),
    .dut_active(dut_active), .stim_done(stim_done),
    .test_done(test_done), .error(error),
    .dut_nreset(dut_nreset), .start(start),
    .finish(finish), .pass(pass), .fail(fail),
    .timeout(timeout), .cycles(cycles)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Expected behaviour derived from event times:
  // s_i start edge, c completion edge, kto watchdog edge.
  task automatic run_case(input string name);
    int s[N];
    int smax, d, c, kto, endk, kk, ecyc;
    bit to, err, fin;
    logic [N-1:0] est;
    nreset     = 1'b0;
    dut_active = '0;
    stim_done  = '0;
    test_done  = '0;
    error      = '0;
    repeat (2) @(negedge clk);
    chk({name, ":reset_outs"},
        32'({dut_nreset, start, finish, pass, fail, timeout}), 0);
    chk({name, ":reset_cycles"}, 32'(cycles), 0);
    smax = 0;
    d    = 0;
    for (int i = 0; i < N; i++) begin
      s[i] = (a_t[i] > RC + 1) ? a_t[i] : RC + 1;
      if (s[i] > smax) smax = s[i];
      if (sd_t[i] > d) d = sd_t[i];
      if (td_t[i] > d) d = td_t[i];
    end
    c    = (d > smax + 1) ? d : smax + 1;
    kto  = RC + TMO;
    to   = (c > kto);
    endk = to ? kto : c + DR;
    err  = (err_k > RC) && (err_k <= endk);
    kk   = (abort_k > 0) ? abort_k : endk + 4;
    nreset = 1'b1;
    for (int k = 1; k <= kk; k++) begin
      for (int i = 0; i < N; i++) begin
        dut_active[i] = (k >= a_t[i]) && (k < drop_t[i]);
        stim_done[i]  = (k >= sd_t[i]);
        test_done[i]  = (k >= td_t[i]);
      end
      error = (k == err_k) ? err_val : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) est[i] = (k >= s[i]);
      fin = (k >= endk);
      if (k <= RC) ecyc = 0;
      else if (to) ecyc = ((k < kto - 1) ? k : kto - 1) - RC;
      else ecyc = ((k < c) ? k : c) - RC;
      chk($sformatf("%s:outs@%0d", name, k),
          32'({dut_nreset, start, finish, pass, fail, timeout}),
          32'({(k >= RC), est, fin, fin && !err && !to,
               fin && (err || to), fin && to}));
      chk($sformatf("%s:cycles@%0d", name, k),
          32'(cycles), 32'(ecyc));
      @(negedge clk);
    end
    if (abort_k > 0) begin
      #2 nreset = 1'b0;
      #1;
      chk({name, ":async_outs"},
          32'({dut_nreset, start, finish, pass, fail, timeout}), 0);
      chk({name, ":async_cycles"}, 32'(cycles), 0);
    end
  endtask

  task automatic set_all(input int a, input int sd,
                         input int td);
    for (int i = 0; i < N; i++) begin
      a_t[i]    = a;
      drop_t[i] = NEVER;
      sd_t[i]   = sd;
      td_t[i]   = td;
    end
    err_k   = -1;
    abort_k = -1;
    err_val = '0;
  endtask

  initial begin
    nreset     = 1'b0;
    dut_active = '0;
    stim_done  = '0;
    test_done  = '0;
    error      = '0;

    set_all(1, 120, 120);
    run_case("basic");

    set_all(1, 150, 150);
    a_t[0] = 30; a_t[1] = 45; a_t[2] = 60; a_t[3] = 90;
    drop_t[1] = 70;
    run_case("stagger");

    set_all(1, 50, NEVER);
    run_case("watchdog");

    set_all(1, 130, 130);
    err_k = 80; err_val = 4'b0100;
    run_case("err_pulse");

    set_all(1, 220, 220);
    run_case("tie_edge");

    set_all(1, 20, 30);
    run_case("done_early");

    set_all(1, 100, 100);
    err_k = 60; err_val = 4'b0001;
    abort_k = 108;
    run_case("abort_drain");

    set_all(1, 90, 90);
    run_case("after_abort");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        a_t[i]  = $urandom_range(1, 40);
        drop_t[i] = ($urandom_range(0, 1) == 1) ?
                    NEVER : 42 + $urandom_range(0, 60);
        sd_t[i] = $urandom_range(10, 200);
        td_t[i] = $urandom_range(30, 235);
      end
      err_k   = ($urandom_range(0, 1) == 1) ?
                $urandom_range(1, 260) : -1;
      err_val = 4'(1 << $urandom_range(0, N - 1));
      abort_k = -1;
      run_case($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
